serial_bit_feeder: RTL and testbench

//   Parallel-to-serial stage that sits directly upstream of the serial-input sequence FSM.

---
 rtl/serial_bit_feeder_pkg.sv | 21 ++
 rtl/serial_bit_feeder_if.sv | 27 ++
 rtl/serial_bit_feeder_piso_shift_reg.sv | 33 +++
 rtl/serial_bit_feeder.sv | 126 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_bit_feeder_pkg.sv
// Shared types for the serial bit feeder.
// PARITY_EN adds a trailing even-parity bit to each frame.
package serial_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle for the serial bit feeder.
// slave is the feeder's view, master the producer/observer's.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output in_data, in_valid,
    input  in_ready, x, x_valid,
    input  busy, frame_done
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x, x_valid,
    output busy, frame_done
  );

endinterface

// File: rtl/serial_bit_feeder_piso_shift_reg.sv
// Load/shift register; the head bit is the serial output.
// fill enters at the tail so a trailing bit can ride along.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic             cur
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      if (MSB_FIRST)
        sr <= {sr[WIDTH-2:0], fill};
      else
        sr <= {fill, sr[WIDTH-1:1]};
    end
  end

  assign cur = MSB_FIRST ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one word in, one bit per clock out.
// Define PARITY_EN to append an even-parity bit per frame.
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  serial_bit_feeder_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            xfer, shift, fill;
  logic            xv_q, fd_q, rdy_q;
  logic            xv_n, fd_n, rdy_n;

  assign xfer  = bus.in_valid & rdy_q;
  assign shift = (state != IDLE) & ~xfer;

`ifdef PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst)
      par_q <= 1'b0;
    else if (xfer)
      par_q <= ^bus.in_data;
  end

  // First shift plants parity at the tail; it
  // reaches the head right after the last payload bit.
  assign fill = (state == SHIFT) &&
                (cnt == '0) && par_q;
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      xv_q  <= 1'b0;
      fd_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      xv_q  <= xv_n;
      fd_q  <= fd_n;
      rdy_q <= rdy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_n = cnt + CW'(1);
`ifdef PARITY_EN
        end else begin
          state_n = PARITY;
        end
`else
        end else if (xfer) begin
          cnt_n = '0;
        end else begin
          state_n = IDLE;
        end
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        if (xfer) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    xv_n = (state_n != IDLE);
`ifdef PARITY_EN
    fd_n = (state_n == PARITY);
`else
    fd_n = (state_n == SHIFT) &&
           (cnt_n == LAST);
`endif
    rdy_n = (state_n == IDLE) | fd_n;
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_sr (
    .clk   (clk),
    .rst   (rst),
    .load  (xfer),
    .shift (shift),
    .fill  (fill),
    .d     (bus.in_data),
    .cur   (bus.x)
  );

  assign bus.x_valid    = xv_q;
  assign bus.busy       = xv_q;
  assign bus.frame_done = fd_q;
  assign bus.in_ready   = rdy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder.
// Two DUTs: MSB-first (a) and LSB-first (b).
module tb_serial_bit_feeder;

`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FLEN = 8 + int'(PAR);

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(8)) ba ();
  serial_bit_feeder_if #(.WIDTH(8)) bb ();

  serial_bit_feeder #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  serial_bit_feeder #(
    .WIDTH     (8),
    .MSB_FIRST (1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  typedef struct packed {
    logic x;
    logic fd;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   run_a  = 0;
  int   last_a = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic observe(input int which,
                         input logic xv,
                         input logic x,
                         input logic fd,
                         input logic busy,
                         input logic rdy);
    exp_t e;
    int   sz;
    string p;
    p  = (which == 0) ? "a_" : "b_";
    sz = (which == 0) ? qa.size() : qb.size();
    check({p, "busy"}, busy, xv);
    if (xv) begin
      check({p, "rdy_fd"}, rdy, fd);
      if (sz == 0) begin
        check({p, "extra_bit"}, xv, 1'b0);
      end else begin
        if (which == 0) e = qa.pop_front();
        else            e = qb.pop_front();
        check({p, "x"}, x, e.x);
        check({p, "fd"}, fd, e.fd);
      end
    end else begin
      check({p, "idle_x"}, x, 1'b0);
      check({p, "idle_fd"}, fd, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    observe(0, ba.x_valid, ba.x,
            ba.frame_done, ba.busy,
            ba.in_ready);
    observe(1, bb.x_valid, bb.x,
            bb.frame_done, bb.busy,
            bb.in_ready);
    if (ba.x_valid) begin
      run_a++;
    end else if (run_a > 0) begin
      last_a = run_a;
      run_a  = 0;
    end
  end

  task automatic push(input int which,
                      input logic [7:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.x  = (which == 0) ? w[7-i] : w[i];
      e.fd = (i == 7) && !PAR;
      if (which == 0) qa.push_back(e);
      else            qb.push_back(e);
    end
    if (PAR) begin
      e.x  = ^w;
      e.fd = 1'b1;
      if (which == 0) qa.push_back(e);
      else            qb.push_back(e);
    end
  endtask

  task automatic send(input int which,
                      input logic [7:0] w);
    logic rdy;
    int   t;
    t = 0;
    if (which == 0) begin
      ba.in_data  = w;
      ba.in_valid = 1'b1;
    end else begin
      bb.in_data  = w;
      bb.in_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      rdy = (which == 0) ? ba.in_ready
                         : bb.in_ready;
      if (rdy) break;
      t++;
      if (t > 40) begin
        check("send_timeout", rdy, 1'b1);
        break;
      end
    end
    if (rdy) push(which, w);
    @(posedge clk);
    #1;
    if (which == 0) ba.in_valid = 1'b0;
    else            bb.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 &&
          !ba.x_valid && !bb.x_valid)
        break;
    end
    check("drain", qa.size() + qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim did not end");
    $fatal(1);
  end

  initial begin
    ba.in_valid = 1'b0;
    ba.in_data  = '0;
    bb.in_valid = 1'b0;
    bb.in_data  = '0;
    rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_rdy",  ba.in_ready, 1'b0);
      check("rst_xv",   ba.x_valid, 1'b0);
      check("rst_x",    ba.x, 1'b0);
      check("rst_busy", ba.busy, 1'b0);
      check("rst_fd",   ba.frame_done, 1'b0);
      check("rst_rdy_b", bb.in_ready, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rdy",   ba.in_ready, 1'b1);
    check("post_rst_rdy_b", bb.in_ready, 1'b1);

    send(0, 8'hA5);
    wait_idle();
    check("run_a5", last_a, FLEN);

    send(0, 8'hFF);
    send(0, 8'h00);
    wait_idle();
    check("run_b2b", last_a, 2 * FLEN);

    send(0, 8'hC3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_x",    ba.x, 1'b0);
    check("mid_rst_xv",   ba.x_valid, 1'b0);
    check("mid_rst_busy", ba.busy, 1'b0);
    qa.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_rdy", ba.in_ready, 1'b1);
    send(0, 8'h81);
    wait_idle();

    send(1, 8'h01);
    @(posedge clk);
    #1;
    bb.in_valid = 1'b1;
    bb.in_data  = 8'hFF;
    repeat (5) begin
      check("ign_rdy", bb.in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    bb.in_valid = 1'b0;
    wait_idle();

    send(0, 8'h07);
    wait_idle();
    send(0, 8'h03);
    wait_idle();

    for (int i = 0; i < 4; i++)
      send(1, 8'($urandom_range(0, 255)));
    wait_idle();

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
